// File: rtl/complex_rot_trivial_pipe.sv
// Two-stage ready/valid rotator multiplying a packed complex sample by 1, -j, -1 or +j.
// Define ROT_SAT_EN to saturate negation of the most negative value instead of wrapping.
module complex_rot_trivial_pipe #(
    parameter int DW = 16,
    parameter int TW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*DW-1:0] in_data,
    input  logic [1:0]      in_rot,
    input  logic [TW-1:0]   in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*DW-1:0] out_data,
    output logic [TW-1:0]   out_tag,
    output logic            ovf,
    input  logic            clr_ovf
);

    typedef enum logic [1:0] {
        ROT_ONE     = 2'b00,
        ROT_NEG_J   = 2'b01,
        ROT_NEG_ONE = 2'b10,
        ROT_POS_J   = 2'b11
    } rot_e;

    localparam logic [DW-1:0] MIN_VAL = {1'b1, {(DW-1){1'b0}}};
`ifdef ROT_SAT_EN
    localparam logic [DW-1:0] MAX_VAL = {1'b0, {(DW-1){1'b1}}};
`endif

    // Only the most negative operand can misbehave; it saturates or wraps by build.
    function automatic logic [DW-1:0] negate(input logic [DW-1:0] x);
        logic [DW-1:0] r;
        r = -x;
`ifdef ROT_SAT_EN
        if (x == MIN_VAL) r = MAX_VAL;
`endif
        return r;
    endfunction

    logic            v1_q, v1_d;
    logic [2*DW-1:0] s1Data_q, s1Data_d;
    rot_e            s1Rot_q, s1Rot_d;
    logic [TW-1:0]   s1Tag_q, s1Tag_d;

    logic            v2_q, v2_d;
    logic [2*DW-1:0] outData_q, outData_d;
    logic [TW-1:0]   outTag_q, outTag_d;
    logic            ovf_q, ovf_d;

    logic            adv1, adv2;
    logic [DW-1:0]   s1Re, s1Im;
    logic [DW-1:0]   rotRe, rotIm;
    logic            negHit;

    assign adv2 = !v2_q || out_ready;
    assign adv1 = !v1_q || adv2;

    assign s1Re = s1Data_q[2*DW-1:DW];
    assign s1Im = s1Data_q[DW-1:0];

    always_comb begin
        rotRe  = s1Re;
        rotIm  = s1Im;
        negHit = 1'b0;
        case (s1Rot_q)
            ROT_ONE: begin
                rotRe = s1Re;
                rotIm = s1Im;
            end
            ROT_NEG_J: begin
                rotRe  = s1Im;
                rotIm  = negate(s1Re);
                negHit = (s1Re == MIN_VAL);
            end
            ROT_NEG_ONE: begin
                rotRe  = negate(s1Re);
                rotIm  = negate(s1Im);
                negHit = (s1Re == MIN_VAL) || (s1Im == MIN_VAL);
            end
            ROT_POS_J: begin
                rotRe  = negate(s1Im);
                rotIm  = s1Re;
                negHit = (s1Im == MIN_VAL);
            end
        endcase
    end

    always_comb begin
        v1_d      = v1_q;
        s1Data_d  = s1Data_q;
        s1Rot_d   = s1Rot_q;
        s1Tag_d   = s1Tag_q;
        v2_d      = v2_q;
        outData_d = outData_q;
        outTag_d  = outTag_q;

        if (adv1) begin
            v1_d = in_valid;
            if (in_valid) begin
                s1Data_d = in_data;
                s1Rot_d  = rot_e'(in_rot);
                s1Tag_d  = in_tag;
            end
        end

        // A bubble in S1 still advances S2 so a consumed output is not repeated.
        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                outData_d = {rotRe, rotIm};
                outTag_d  = s1Tag_q;
            end
        end

        ovf_d = (adv2 && v1_q && negHit) || (ovf_q && !clr_ovf);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q      <= 1'b0;
            s1Data_q  <= '0;
            s1Rot_q   <= ROT_ONE;
            s1Tag_q   <= '0;
            v2_q      <= 1'b0;
            outData_q <= '0;
            outTag_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            v1_q      <= v1_d;
            s1Data_q  <= s1Data_d;
            s1Rot_q   <= s1Rot_d;
            s1Tag_q   <= s1Tag_d;
            v2_q      <= v2_d;
            outData_q <= outData_d;
            outTag_q  <= outTag_d;
            ovf_q     <= ovf_d;
        end
    end

    assign in_ready  = adv1;
    assign out_valid = v2_q;
    assign out_data  = outData_q;
    assign out_tag   = outTag_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_complex_rot_trivial_pipe.sv
// Bench for complex_rot_trivial_pipe: directed vector table, reset/ovf corner sequences,
// and randomized streams scored against an integer-arithmetic model (honours ROT_SAT_EN).
module tb_complex_rot_trivial_pipe;

    localparam int DW = 16;
    localparam int TW = 8;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [2*DW-1:0] in_data;
    logic [1:0]      in_rot;
    logic [TW-1:0]   in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [2*DW-1:0] out_data;
    logic [TW-1:0]   out_tag;
    logic            ovf;
    logic            clr_ovf;

    complex_rot_trivial_pipe #(.DW(DW), .TW(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_rot    (in_rot),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .ovf       (ovf),
        .clr_ovf   (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2*DW-1:0] data;
        logic [1:0]      rot;
        logic [TW-1:0]   tag;
        logic [2*DW-1:0] expData;
        bit              expOvf;
    } vec_t;

    typedef struct {
        logic [2*DW-1:0] data;
        logic [TW-1:0]   tag;
        bit              hit;
    } exp_t;

    vec_t tbl[10];
    exp_t expQ[$];
    int   checks = 0;
    int   failures = 0;
    bit   ovfAcc;

`ifdef ROT_SAT_EN
    localparam logic [2*DW-1:0] EXP_C5 = 32'h0001_7FFF;
    localparam logic [2*DW-1:0] EXP_C6 = 32'h7FFF_7FFF;
    localparam logic [2*DW-1:0] EXP_C7 = 32'h7FFF_0000;
`else
    localparam logic [2*DW-1:0] EXP_C5 = 32'h0001_8000;
    localparam logic [2*DW-1:0] EXP_C6 = 32'h8000_8000;
    localparam logic [2*DW-1:0] EXP_C7 = 32'h8000_0000;
`endif

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2*DW-1:0] d, input logic [1:0] r, input logic [TW-1:0] t, input logic v);
        in_data  = d;
        in_rot   = r;
        in_tag   = t;
        in_valid = v;
    endtask

    // Signed negation on the integer line, then fold back into DW bits.
    function automatic logic [DW-1:0] negModel(input logic [DW-1:0] x, output bit hit);
        int v;
        int n;
        v   = int'($signed(x));
        n   = -v;
        hit = 1'b0;
        if (n > (2 ** (DW - 1)) - 1) begin
            hit = 1'b1;
`ifdef ROT_SAT_EN
            n = (2 ** (DW - 1)) - 1;
`else
            n = v;
`endif
        end
        return n[DW-1:0];
    endfunction

    function automatic void rotModel(input logic [2*DW-1:0] d, input logic [1:0] rot,
                                     output logic [2*DW-1:0] r, output bit hit);
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        bit h1;
        bit h2;
        a  = d[2*DW-1:DW];
        b  = d[DW-1:0];
        h1 = 1'b0;
        h2 = 1'b0;
        case (rot)
            2'd0:    r = {a, b};
            2'd1:    r = {b, negModel(a, h1)};
            2'd2:    r = {negModel(a, h1), negModel(b, h2)};
            default: r = {negModel(b, h1), a};
        endcase
        hit = h1 | h2;
    endfunction

    function automatic logic [2*DW-1:0] genData();
        logic [2*DW-1:0] d;
        d = $urandom;
        if ($urandom_range(0, 7) == 0) d[2*DW-1:DW] = 16'h8000;
        if ($urandom_range(0, 7) == 0) d[DW-1:0] = 16'h8000;
        return d;
    endfunction

    // One sample through an otherwise idle pipe with out_ready high: visible exactly 2 cycles later.
    task automatic runSingle(input vec_t v);
        out_ready = 1'b1;
        applyStimulus(v.data, v.rot, v.tag, 1'b1);
        checkOutput("single_in_ready", 64'(in_ready), 64'd1);
        tick();
        applyStimulus('0, 2'b00, '0, 1'b0);
        checkOutput("single_valid_early", 64'(out_valid), 64'd0);
        tick();
        checkOutput("single_valid", 64'(out_valid), 64'd1);
        checkOutput("single_data", 64'(out_data), 64'(v.expData));
        checkOutput("single_tag", 64'(out_tag), 64'(v.tag));
        checkOutput("single_ovf", 64'(ovf), 64'(v.expOvf));
        tick();
        checkOutput("single_valid_after", 64'(out_valid), 64'd0);
    endtask

    task automatic pulseClear();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
    endtask

    // mode 0: continuous input, out_ready low on cycles 3..7; mode 1: random valid/ready.
    task automatic runStream(input int nSamples, input int mode, input int maxCycles);
        int              sent;
        int              got;
        bit              holdPending;
        logic [2*DW-1:0] heldData;
        logic [TW-1:0]   heldTag;
        logic [2*DW-1:0] r;
        bit              h;
        exp_t            e;
        sent        = 0;
        got         = 0;
        holdPending = 1'b0;
        heldData    = '0;
        heldTag     = '0;
        pulseClear();
        ovfAcc = 1'b0;
        expQ.delete();
        for (int c = 0; c < maxCycles && got < nSamples; c++) begin
            if (sent < nSamples && (mode == 0 || $urandom_range(0, 9) < 7))
                applyStimulus(genData(), 2'($urandom_range(0, 3)), TW'(sent), 1'b1);
            else
                applyStimulus('0, 2'b00, '0, 1'b0);
            if (mode == 0) out_ready = !(c >= 3 && c <= 7);
            else           out_ready = ($urandom_range(0, 9) < 7);
            #1;
            if (holdPending) begin
                checkOutput("hold_valid", 64'(out_valid), 64'd1);
                checkOutput("hold_data", 64'(out_data), 64'(heldData));
                checkOutput("hold_tag", 64'(out_tag), 64'(heldTag));
            end
            if (mode == 0 && c == 4) checkOutput("bp_in_ready_low", 64'(in_ready), 64'd0);
            if (out_valid && out_ready) begin
                checkOutput("stream_exp_available", 64'(expQ.size() != 0), 64'd1);
                if (expQ.size() != 0) begin
                    e      = expQ.pop_front();
                    ovfAcc = ovfAcc | e.hit;
                    checkOutput("stream_data", 64'(out_data), 64'(e.data));
                    checkOutput("stream_tag", 64'(out_tag), 64'(e.tag));
                    checkOutput("stream_ovf", 64'(ovf), 64'(ovfAcc));
                end
                got++;
                holdPending = 1'b0;
            end else if (out_valid) begin
                holdPending = 1'b1;
                heldData    = out_data;
                heldTag     = out_tag;
            end else begin
                holdPending = 1'b0;
            end
            if (in_valid && in_ready) begin
                rotModel(in_data, in_rot, r, h);
                expQ.push_back('{r, in_tag, h});
                sent++;
            end
            @(posedge clk);
            #1;
        end
        applyStimulus('0, 2'b00, '0, 1'b0);
        out_ready = 1'b1;
        checkOutput("stream_count", 64'(got), 64'(nSamples));
        checkOutput("stream_leftover", 64'(expQ.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tbl[0] = '{32'h1234_0567, 2'b01, 8'h05, 32'h0567_EDCC, 1'b0};
        tbl[1] = '{32'h1000_2000, 2'b00, 8'h00, 32'h1000_2000, 1'b0};
        tbl[2] = '{32'h1000_2000, 2'b01, 8'h01, 32'h2000_F000, 1'b0};
        tbl[3] = '{32'h1000_2000, 2'b10, 8'h02, 32'hF000_E000, 1'b0};
        tbl[4] = '{32'h1000_2000, 2'b11, 8'h03, 32'hE000_1000, 1'b0};
        tbl[5] = '{32'h8000_0001, 2'b01, 8'h11, EXP_C5,        1'b1};
        tbl[6] = '{32'h8000_8000, 2'b10, 8'h22, EXP_C6,        1'b1};
        tbl[7] = '{32'h0000_8000, 2'b11, 8'h33, EXP_C7,        1'b1};
        tbl[8] = '{32'h8000_7FFF, 2'b00, 8'h44, 32'h8000_7FFF, 1'b0};
        tbl[9] = '{32'h7FFF_8001, 2'b10, 8'h55, 32'h8001_7FFF, 1'b0};

        rst       = 1'b1;
        clr_ovf   = 1'b0;
        out_ready = 1'b1;
        applyStimulus('0, 2'b00, '0, 1'b0);

        #12;
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_out_data", 64'(out_data), 64'd0);
        checkOutput("reset_out_tag", 64'(out_tag), 64'd0);
        checkOutput("reset_ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 10; i++) begin
            pulseClear();
            checkOutput("tbl_ovf_cleared", 64'(ovf), 64'd0);
            runSingle(tbl[i]);
        end

        // Back-to-back stream: outputs on four consecutive cycles, two cycles behind inputs.
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c < 4) applyStimulus(tbl[1 + c].data, tbl[1 + c].rot, tbl[1 + c].tag, 1'b1);
            else       applyStimulus('0, 2'b00, '0, 1'b0);
            checkOutput("b2b_in_ready", 64'(in_ready), 64'd1);
            checkOutput("b2b_valid", 64'(out_valid), 64'(c >= 2));
            if (c >= 2) begin
                checkOutput("b2b_data", 64'(out_data), 64'(tbl[c - 1].expData));
                checkOutput("b2b_tag", 64'(out_tag), 64'(tbl[c - 1].tag));
            end
            tick();
        end

        // Overflow set and clear arriving in the same cycle: set wins.
        pulseClear();
        applyStimulus(32'h8000_8000, 2'b10, 8'h09, 1'b1);
        tick();
        applyStimulus('0, 2'b00, '0, 1'b0);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        checkOutput("setclr_valid", 64'(out_valid), 64'd1);
        checkOutput("setclr_ovf", 64'(ovf), 64'd1);
        tick();

        // Asynchronous reset with both stages occupied.
        out_ready = 1'b0;
        applyStimulus(32'h0101_0202, 2'b00, 8'hA0, 1'b1);
        tick();
        applyStimulus(32'h0303_0404, 2'b01, 8'hA1, 1'b1);
        tick();
        applyStimulus('0, 2'b00, '0, 1'b0);
        checkOutput("arst_pre_valid", 64'(out_valid), 64'd1);
        checkOutput("arst_pre_in_ready", 64'(in_ready), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_valid_now", 64'(out_valid), 64'd0);
        checkOutput("arst_data_now", 64'(out_data), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        tick();
        checkOutput("arst_valid_after1", 64'(out_valid), 64'd0);
        tick();
        checkOutput("arst_valid_after2", 64'(out_valid), 64'd0);
        checkOutput("arst_in_ready", 64'(in_ready), 64'd1);
        runSingle(tbl[0]);

        runStream(6, 0, 60);
        runStream(300, 1, 3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/complex_rot_trivial_pipe.md
Name: complex_rot_trivial_pipe

Overview:
- Pipelined, parametrised trivial-twiddle rotator for the FFT datapath.
- Multiplies a packed complex sample by one of {1, -j, -1, +j}, selected per sample.
- Uses ready/valid handshake with full backpressure.
- Replaces the fixed combinational W_N^{N/4} stage in butterfly columns where the twiddle index resolves to a quadrant rotation; also carries a sticky overflow flag for the negation corner case.

Parameters:
- DW, 16: width of each real/imag component; two's complement.
- TW, 8: width of the sideband tag carried alongside each sample (e.g. FFT bin index).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept the input this cycle.
- in_data  in  2*DW  {real[2*DW-1:DW], imag[DW-1:0]}.
- in_rot  in  2  rotation select: 00 = x1, 01 = x(-j), 10 = x(-1), 11 = x(+j).
- in_tag  in  TW  sideband, passed through unchanged.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts output.
- out_data  out  2*DW  rotated sample, same packing as in_data.
- out_tag  out  TW  tag of the sample on out_data.
- ovf  out  1  sticky: set when any negation of the value -2^(DW-1) occurs.
- clr_ovf  in  1  synchronous clear of ovf.

Behaviour:
- Reset (async, rst=1): v1=v2=0, out_valid=0, out_data=0, out_tag=0, ovf=0. in_ready=1 once rst deasserts. Reset mid-operation discards both stages; no sample emerges.
- Pipeline has two register stages:
  - S1 captures {in_data, in_rot, in_tag} on input handshake.
  - S2 computes the rotation from S1 and registers out_data/out_tag.
- Latency: 2 cycles from input handshake to out_valid with out_ready held high. Throughput is 1 sample/cycle.
- Handshake:
  - adv2 = !v2 | out_ready.
  - adv1 = !v1 | adv2.
  - in_ready = adv1. This is combinational from out_ready; no combinational in_valid to out_valid path.
- Transfers:
  - Input transfers when in_valid & in_ready.
  - Output transfers when out_valid & out_ready.
  - out_data/out_tag hold stable while out_valid & !out_ready.
- Rotation, with a = real, b = imag:
  - 00: {a, b}.
  - 01: {b, -a}.
  - 10: {-a, -b}.
  - 11: {-b, a}.
- Negation is two's complement on DW bits. The single corner case is the operand -2^(DW-1); its handling is defined under Optional Feature.
- ovf:
  - Set in the cycle the offending sample is registered into S2.
  - Cleared by clr_ovf.
  - Set has priority over clr in the same cycle.
  - Rotation 00 never sets ovf.
- Simultaneous in and out handshakes with both stages full: the pipeline shifts, with no bubble and no drop.
- Bubbles: S2 loads a bubble (v2=0) when v1=0 and adv2=1.

Optional Feature:
- Macro ROT_SAT_EN.
- Defined: negating -2^(DW-1) yields +2^(DW-1)-1 (saturate), and ovf is set.
- Undefined: the result wraps to -2^(DW-1), and ovf is still set, so a wrap is always visible to software.
- All other results are identical in both builds.

Test Plan:
- Reset then single sample, DW=16, in_data=0x1234_0567, rot=01, out_ready=1 -> out_valid 2 cycles later, out_data=0x0567_EDCC, ovf=0.
- Back-to-back stream of four samples 0x1000_2000 with rot=00, 01, 10, 11 and tags 0..3 -> outputs on four consecutive cycles: 0x1000_2000, 0x2000_F000, 0xF000_E000, 0xE000_1000; tags in order 0..3.
- Backpressure: stream 6 samples, out_ready=0 for cycles 3–7 -> in_ready drops after both stages fill, out_data holds stable, all 6 samples emerge in order with none lost or duplicated.
- Corner: in_data=0x8000_0001, rot=01 -> with ROT_SAT_EN out_data=0x0001_7FFF, ovf=1; without it out_data=0x0001_8000, ovf=1. Then clr_ovf=1 -> ovf=0.
- rst asserted asynchronously while 2 samples are in flight -> out_valid=0 immediately and stays 0 after release; the next input emerges normally with latency 2.
- Simultaneous ovf set and clr_ovf: 0x8000_8000 rot=10 arriving in S2 while clr_ovf=1 -> ovf=1.
